// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared framebuffer geometry and RGB222 field layout for the
//                180x120 SRAM framebuffer (writer and scan-out reader sides).
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int H_PIXELS      = 180;
  localparam int V_PIXELS      = 120;
  localparam int FB_DEPTH      = H_PIXELS * V_PIXELS;
  localparam int FB_ADDR_WIDTH = $clog2(FB_DEPTH);

  // Packed RGB222 word: {R2,G2,B2}
  localparam int RGB6_R_LSB = 4;
  localparam int RGB6_G_LSB = 2;
  localparam int RGB6_B_LSB = 0;

  typedef logic [5:0] rgb6_t;

endpackage
`default_nettype wire

// File: rtl/rgb24_to_rgb6.sv
`default_nettype none
// ============================================================================
//  Module      : rgb24_to_rgb6
//  Description : Combinational RGB888 -> RGB222 channel reduction. Mirror of
//                rgb6_to_rgb24 on the scan-out side.
//                Build option FB_WRITER_DITHER_EN: 2x2 ordered (Bayer) dither
//                (thresholds {0,32;48,16} indexed by {y[0],x[0]}) is added
//                per channel with saturation before keeping bits [7:6].
//                Without it, plain truncation to bits [7:6].
//  Ports       : i_rgb24 [23:0] {R8,G8,B8} input pixel
//                i_x_lsb        pixel column LSB (dither index)
//                i_y_lsb        pixel row LSB (dither index)
//                o_rgb6  [5:0]  {R2,G2,B2} reduced pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb24_to_rgb6
  import fb_pkg::*;
(
  input  logic [23:0] i_rgb24,
  input  logic        i_x_lsb,
  input  logic        i_y_lsb,
  output rgb6_t       o_rgb6
);

`ifdef FB_WRITER_DITHER_EN
  logic [7:0] thr;

  always_comb begin
    thr = 8'd0;
    case ({i_y_lsb, i_x_lsb})
      2'b00:   thr = 8'd0;
      2'b01:   thr = 8'd32;
      2'b10:   thr = 8'd48;
      default: thr = 8'd16;
    endcase
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [7:0] chan;
    logic [8:0] sum;
    assign chan = i_rgb24[c*8 +: 8];
    assign sum  = {1'b0, chan} + {1'b0, thr};
    // A carry out means the sum saturated at 255, whose top bits are 2'b11.
    assign o_rgb6[c*2 +: 2] = sum[8] ? 2'b11 : sum[7:6];
  end
`else
  logic unused_xy;
  assign unused_xy = i_x_lsb ^ i_y_lsb;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [7:0] chan;
    logic [5:0] unused_low;
    assign chan             = i_rgb24[c*8 +: 8];
    assign unused_low       = chan[5:0];
    assign o_rgb6[c*2 +: 2] = chan[7:6];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_framebuffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_framebuffer_writer
//  Description : Write side of the 180x120 RGB222 SRAM framebuffer. Takes a
//                raster-ordered RGB888 valid/ready stream with start-of-frame,
//                reduces it to RGB222, queues {addr,rgb6} in a small FIFO and
//                drains into the SRAM only while i_writeWindow is granted.
//                Build option FB_WRITER_DITHER_EN enables 2x2 ordered dither
//                in the colour reduction; ports and timing are unchanged.
//  Ports       : crystalCLK       clock (only clock)
//                resetN           asynchronous active-low reset
//                i_pixelValid     input pixel valid
//                o_pixelReady     input pixel ready (FIFO not full)
//                i_startOfFrame   current beat is pixel (0,0)
//                i_rgb24Pixel     {R8,G8,B8}
//                i_writeWindow    SRAM port granted this cycle
//                o_sramAddress    registered write address
//                o_sramWrData     registered {R2,G2,B2}
//                o_sramWre        registered write enable
//                o_frameDone      pulse with the write of address H*V-1
//                o_shortFrame     pulse when SOF arrives mid-frame
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_framebuffer_writer
  import fb_pkg::*;
#(
  parameter  int H_PIXELS   = fb_pkg::H_PIXELS,
  parameter  int V_PIXELS   = fb_pkg::V_PIXELS,
  parameter  int FIFO_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(H_PIXELS * V_PIXELS)
) (
  input  logic                  crystalCLK,
  input  logic                  resetN,
  input  logic                  i_pixelValid,
  output logic                  o_pixelReady,
  input  logic                  i_startOfFrame,
  input  logic [23:0]           i_rgb24Pixel,
  input  logic                  i_writeWindow,
  output logic [ADDR_WIDTH-1:0] o_sramAddress,
  output logic [5:0]            o_sramWrData,
  output logic                  o_sramWre,
  output logic                  o_frameDone,
  output logic                  o_shortFrame
);

  localparam int DEPTH   = H_PIXELS * V_PIXELS;
  localparam int XW      = $clog2(H_PIXELS);
  localparam int YW      = $clog2(V_PIXELS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_WIDTH + 6;

  localparam logic [XW-1:0]         X_LAST    = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]         Y_LAST    = YW'(V_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  // Ingress raster position
  logic [XW-1:0]         x_q, x_d, pos_x;
  logic [YW-1:0]         y_q, y_d, pos_y;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pos_addr;
  logic                  short_q, short_d;

  // FIFO: pointers carry an extra wrap bit to separate full from empty
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     wr_vis_q;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  rgb6_t              rgb6;

  // SRAM-side output registers
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [5:0]            sram_data_q, sram_data_d;
  logic                  wre_q, wre_d;
  logic                  frame_done_q, frame_done_d;

  rgb24_to_rgb6 u_rgb24_to_rgb6 (
    .i_rgb24 (i_rgb24Pixel),
    .i_x_lsb (pos_x[0]),
    .i_y_lsb (pos_y[0]),
    .o_rgb6  (rgb6)
  );

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // Emptiness is judged against a one-cycle-delayed write pointer so a new
  // entry becomes poppable the cycle after it is written; this gives the
  // fixed accept-to-strobe latency of two edges and keeps the memory write
  // and read in separate cycles.
  assign empty = (wr_vis_q == rd_ptr_q);
  assign push  = i_pixelValid & ~full;
  assign pop   = ~empty & i_writeWindow;

  assign o_pixelReady = ~full;
  assign wr_entry     = {pos_addr, rgb6};
  assign rd_entry     = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Ingress position: SOF forces (0,0)/addr 0 for the current beat
  always_comb begin
    pos_x    = x_q;
    pos_y    = y_q;
    pos_addr = addr_q;
    if (i_startOfFrame) begin
      pos_x    = '0;
      pos_y    = '0;
      pos_addr = '0;
    end

    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    short_d = 1'b0;
    if (push) begin
      if (pos_x == X_LAST) begin
        x_d = '0;
        y_d = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
      end else begin
        x_d = pos_x + XW'(1);
      end
      addr_d  = (pos_addr == ADDR_LAST) ? '0 : pos_addr + ADDR_WIDTH'(1);
      short_d = i_startOfFrame && (addr_q != '0);
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d     = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    wre_d        = pop;
    sram_addr_d  = sram_addr_q;
    sram_data_d  = sram_data_q;
    frame_done_d = 1'b0;
    if (pop) begin
      sram_addr_d  = rd_entry[ENTRY_W-1:6];
      sram_data_d  = rd_entry[5:0];
      frame_done_d = (rd_entry[ENTRY_W-1:6] == ADDR_LAST);
    end
  end

  always_ff @(posedge crystalCLK or negedge resetN) begin
    if (!resetN) begin
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      short_q      <= 1'b0;
      wr_ptr_q     <= '0;
      wr_vis_q     <= '0;
      rd_ptr_q     <= '0;
      sram_addr_q  <= '0;
      sram_data_q  <= '0;
      wre_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      short_q      <= short_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_vis_q     <= wr_ptr_q;
      rd_ptr_q     <= rd_ptr_d;
      sram_addr_q  <= sram_addr_d;
      sram_data_q  <= sram_data_d;
      wre_q        <= wre_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage array needs no reset: pointers alone define valid contents.
  always_ff @(posedge crystalCLK) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
    end
  end

  assign o_sramAddress = sram_addr_q;
  assign o_sramWrData  = sram_data_q;
  assign o_sramWre     = wre_q;
  assign o_frameDone   = frame_done_q;
  assign o_shortFrame  = short_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_framebuffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_framebuffer_writer
//  Description : Directed self-checking bench for sram_framebuffer_writer with
//                an expected-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_framebuffer_writer;
  import fb_pkg::*;

  logic        crystalCLK = 1'b0;
  logic        resetN = 1'b0;
  logic        i_pixelValid = 1'b0;
  logic        i_startOfFrame = 1'b0;
  logic [23:0] i_rgb24Pixel = '0;
  logic        i_writeWindow = 1'b0;
  logic        o_pixelReady;
  logic [FB_ADDR_WIDTH-1:0] o_sramAddress;
  logic [5:0]  o_sramWrData;
  logic        o_sramWre;
  logic        o_frameDone;
  logic        o_shortFrame;

  sram_framebuffer_writer dut (
    .crystalCLK     (crystalCLK),
    .resetN         (resetN),
    .i_pixelValid   (i_pixelValid),
    .o_pixelReady   (o_pixelReady),
    .i_startOfFrame (i_startOfFrame),
    .i_rgb24Pixel   (i_rgb24Pixel),
    .i_writeWindow  (i_writeWindow),
    .o_sramAddress  (o_sramAddress),
    .o_sramWrData   (o_sramWrData),
    .o_sramWre      (o_sramWre),
    .o_frameDone    (o_frameDone),
    .o_shortFrame   (o_shortFrame)
  );

  always #5 crystalCLK = ~crystalCLK;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   mx = 0, my = 0, maddr = 0;
  int   wr_count = 0, fd_count = 0, last_addr = -1;
  int   base_wr, base_fd;
  bit   rand_win = 1'b0;
  logic [5:0] wr_mem [0:FB_DEPTH-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int conv(input logic [23:0] p, input int x, input int y);
    int thr;
    int r;
    int v;
`ifdef FB_WRITER_DITHER_EN
    if (y % 2 == 0) thr = (x % 2 == 0) ? 0 : 32;
    else            thr = (x % 2 == 0) ? 48 : 16;
`else
    thr = 0;
`endif
    r = 0;
    for (int c = 2; c >= 0; c--) begin
      v = int'(p[c*8 +: 8]) + thr;
      if (v > 255) v = 255;
      r = (r << 2) | (v >> 6);
    end
    return r;
  endfunction

  // Scoreboard consumer: every SRAM strobe must match the oldest expected write
  always @(negedge crystalCLK) begin
    if (resetN && o_sramWre) begin
      exp_t e;
      e.addr = -1;
      e.data = -1;
      if (sb.size() > 0) e = sb.pop_front();
      check("wr_addr", 32'(o_sramAddress), e.addr);
      check("wr_data", 32'(o_sramWrData), e.data);
      check("frame_done", 32'(o_frameDone), (e.addr == FB_DEPTH - 1) ? 1 : 0);
      wr_mem[o_sramAddress] = o_sramWrData;
      wr_count++;
      if (o_frameDone) fd_count++;
      last_addr = int'(o_sramAddress);
    end
  end

  always @(posedge crystalCLK) begin
    #1;
    if (rand_win) i_writeWindow = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one pixel; returns #1 after the accepting edge
  task automatic push_px(input logic [23:0] rgb, input bit sof);
    bit   acc;
    bit   sh;
    int   guard;
    exp_t e;
    acc = 1'b0;
    sh = 1'b0;
    guard = 0;
    i_pixelValid = 1'b1;
    i_rgb24Pixel = rgb;
    i_startOfFrame = sof;
    while (!acc) begin
      @(negedge crystalCLK);
      acc = o_pixelReady;
      if (acc) begin
        sh = sof && (maddr != 0);
        if (sof) begin
          mx = 0; my = 0; maddr = 0;
        end
        e.addr = maddr;
        e.data = conv(rgb, mx, my);
        sb.push_back(e);
        if (mx == H_PIXELS - 1) begin
          mx = 0;
          my = (my == V_PIXELS - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
        maddr = (maddr == FB_DEPTH - 1) ? 0 : maddr + 1;
      end
      @(posedge crystalCLK);
      #1;
      if (!acc) begin
        guard++;
        if (guard > 1000) begin
          check("push_accept_timeout", guard, 0);
          break;
        end
      end
    end
    if (acc) check("short_frame", 32'(o_shortFrame), 32'(sh));
    i_pixelValid = 1'b0;
    i_startOfFrame = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(posedge crystalCLK);
      g++;
    end
    @(posedge crystalCLK);
    #1;
    check("drain_complete", sb.size(), 0);
  endtask

  logic [23:0] t1_pix [8];

  initial begin
    t1_pix = '{24'hFFFFFF, 24'h000000, 24'hC08040, 24'h3FBF7F,
               24'h80FF00, 24'h4040C0, 24'hFF0080, 24'h7F7F7F};

    // Reset state
    repeat (3) @(posedge crystalCLK);
    #1;
    check("rst_wre", 32'(o_sramWre), 0);
    check("rst_addr", 32'(o_sramAddress), 0);
    check("rst_data", 32'(o_sramWrData), 0);
    check("rst_frame_done", 32'(o_frameDone), 0);
    check("rst_short", 32'(o_shortFrame), 0);
    check("rst_ready", 32'(o_pixelReady), 1);
    @(negedge crystalCLK);
    resetN = 1'b1;
    @(posedge crystalCLK);
    #1;

    // 1: 8 pixels with window held high, 2-edge latency
    i_writeWindow = 1'b1;
    base_wr = wr_count;
    push_px(t1_pix[0], 1'b1);
    check("lat_edge_k0", 32'(o_sramWre), 0);
    @(posedge crystalCLK); #1;
    check("lat_edge_k1", 32'(o_sramWre), 0);
    @(posedge crystalCLK); #1;
    check("lat_edge_k2", 32'(o_sramWre), 1);
    for (int i = 1; i < 8; i++) push_px(t1_pix[i], 1'b0);
    drain();
    check("t1_writes", wr_count - base_wr, 8);
    check("t1_last_addr", last_addr, 7);

    // 2: window closed, FIFO fills to 16 then back-pressures
    i_writeWindow = 1'b0;
    base_wr = wr_count;
    for (int i = 0; i < 16; i++) push_px(24'h010203 * (i + 1), (i == 0));
    i_pixelValid = 1'b1;
    i_rgb24Pixel = 24'hABCDEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge crystalCLK); #1;
      check("t2_ready_low", 32'(o_pixelReady), 0);
      check("t2_no_strobe", 32'(o_sramWre), 0);
    end
    i_pixelValid = 1'b0;
    check("t2_none_written", wr_count - base_wr, 0);
    i_writeWindow = 1'b1;
    drain();
    check("t2_drained", wr_count - base_wr, 16);
    check("t2_last_addr", last_addr, 15);
    for (int i = 0; i < 4; i++) push_px(24'h102030 * (i + 1), 1'b0);
    drain();
    check("t2_tail_last_addr", last_addr, 19);

    // 3: full frame with random window, then wrap to address 0
    base_wr = wr_count;
    base_fd = fd_count;
    rand_win = 1'b1;
    for (int i = 0; i < FB_DEPTH; i++) push_px(24'($urandom), (i == 0));
    push_px(24'h00FF00, 1'b0);
    rand_win = 1'b0;
    i_writeWindow = 1'b1;
    drain();
    check("t3_writes", wr_count - base_wr, FB_DEPTH + 1);
    check("t3_frame_done_count", fd_count - base_fd, 1);
    check("t3_wrap_addr", last_addr, 0);

    // 4: SOF after 100 pixels -> short frame, restart at address 0
    for (int i = 0; i < 100; i++) push_px(24'h203040 + 24'(i), (i == 0));
    push_px(24'hFFFF00, 1'b1);
    @(posedge crystalCLK); #1;
    check("t4_short_pulse_end", 32'(o_shortFrame), 0);
    push_px(24'h00FFFF, 1'b0);
    drain();
    check("t4_last_addr", last_addr, 1);
    check("t4_addr0_data", 32'(wr_mem[0]), 32'h3C);
    check("t4_addr1_data", 32'(wr_mem[1]), 32'h0F);

    // 5: async reset mid-burst with 5 entries queued
    i_writeWindow = 1'b0;
    for (int i = 0; i < 5; i++) push_px(24'h808080, (i == 0));
    @(negedge crystalCLK);
    i_writeWindow = 1'b1;
    @(posedge crystalCLK); #1;
    check("t5_burst_active", 32'(o_sramWre), 1);
    #2;
    resetN = 1'b0;
    #1;
    check("t5_wre_async_clear", 32'(o_sramWre), 0);
    check("t5_addr_async_clear", 32'(o_sramAddress), 0);
    check("t5_ready_in_reset", 32'(o_pixelReady), 1);
    sb.delete();
    mx = 0; my = 0; maddr = 0;
    @(negedge crystalCLK);
    resetN = 1'b1;
    @(posedge crystalCLK); #1;
    check("t5_ready_after", 32'(o_pixelReady), 1);
    base_wr = wr_count;
    push_px(24'hC0C0C0, 1'b1);
    drain();
    check("t5_single_write", wr_count - base_wr, 1);
    check("t5_addr0", last_addr, 0);

    // 6: constant 0x505050 over the 2x2 block at (0,0)
    push_px(24'h505050, 1'b1);
    push_px(24'h505050, 1'b0);
    for (int i = 0; i < H_PIXELS - 2; i++) push_px(24'h000000, 1'b0);
    push_px(24'h505050, 1'b0);
    push_px(24'h505050, 1'b0);
    drain();
`ifdef FB_WRITER_DITHER_EN
    check("t6_px00", 32'(wr_mem[0]), 32'h15);
    check("t6_px10", 32'(wr_mem[1]), 32'h15);
    check("t6_px01", 32'(wr_mem[H_PIXELS]), 32'h2A);
    check("t6_px11", 32'(wr_mem[H_PIXELS + 1]), 32'h15);
`else
    check("t6_px00", 32'(wr_mem[0]), 32'h15);
    check("t6_px10", 32'(wr_mem[1]), 32'h15);
    check("t6_px01", 32'(wr_mem[H_PIXELS]), 32'h15);
    check("t6_px11", 32'(wr_mem[H_PIXELS + 1]), 32'h15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
